// File: rtl/capture_dump_reader.sv
`default_nettype none
// ============================================================================
// Module   : capture_dump_reader
// Purpose  : Reads a window of samples out of the logic-analyzer capture RAM,
//            oldest first with address wrap-around, and serializes them into
//            a byte stream with valid/ready handshaking. Each frame is a
//            2-byte big-endian sample-count header followed by every sample,
//            zero-extended to SAMPLE_BYTES bytes and sent MSB byte first.
// Ports    : clk, rst            - clock, synchronous active-high reset
//            start               - begin a dump (honoured only when idle)
//            start_addr          - RAM address of the oldest sample
//            sample_count        - samples to send (clamped to RAM depth)
//            busy, done          - dump in progress / one-cycle end pulse
//            ram_rd_en/addr/data - capture RAM read port (1-cycle latency)
//            m_tdata/tvalid/tready/tlast - output byte stream
// Revision : 1.0 - initial release
// ============================================================================
module capture_dump_reader #(
  parameter int DATA_WIDTH   = 34,
  parameter int ADDR_WIDTH   = 12,
  parameter int SAMPLE_BYTES = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  input  logic [ADDR_WIDTH:0]   sample_count,
  output logic                  busy,
  output logic                  done,
  output logic                  ram_rd_en,
  output logic [ADDR_WIDTH-1:0] ram_rd_addr,
  input  logic [DATA_WIDTH-1:0] ram_rd_data,
  output logic [7:0]            m_tdata,
  output logic                  m_tvalid,
  input  logic                  m_tready,
  output logic                  m_tlast
);

  localparam int c_shift_w = SAMPLE_BYTES * 8;
  localparam int c_bidx_w  = (SAMPLE_BYTES > 1) ? $clog2(SAMPLE_BYTES) : 1;
  localparam logic [c_bidx_w-1:0]   c_last_byte = c_bidx_w'(SAMPLE_BYTES - 1);
  localparam logic [ADDR_WIDTH:0]   c_max_count = {1'b1, {ADDR_WIDTH{1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_HDR0 = 3'd1,
    S_HDR1 = 3'd2,
    S_RD   = 3'd3,
    S_LAT  = 3'd4,
    S_SEND = 3'd5,
    S_DONE = 3'd6
  } state_t;

  state_t                  r_state;
  state_t                  w_next;
  logic [ADDR_WIDTH:0]     r_count;      // effective (clamped) count, for the header
  logic [ADDR_WIDTH:0]     r_remain;     // samples not yet read from RAM
  logic [ADDR_WIDTH-1:0]   r_addr;       // next RAM address to read
  logic [c_shift_w-1:0]    r_shift;      // current sample, MSB byte at the top
  logic [c_bidx_w-1:0]     r_byte;       // index of the byte being offered
  logic [c_shift_w-1:0]    w_sample_ext;
  logic [ADDR_WIDTH:0]     w_clamped;
  logic [31:0]             w_count32;
  logic [15:0]             w_hdr;
  logic                    w_last_byte;

  // Zero-extend the RAM word to a whole number of stream bytes.
  generate
    if (c_shift_w > DATA_WIDTH) begin : g_ext_pad
      assign w_sample_ext = {{(c_shift_w - DATA_WIDTH){1'b0}}, ram_rd_data};
    end else begin : g_ext_exact
      assign w_sample_ext = ram_rd_data[c_shift_w-1:0];
    end
  endgenerate

  assign w_clamped   = (sample_count > c_max_count) ? c_max_count : sample_count;
  // Header is the count as 16 bits; widen first so any ADDR_WIDTH works.
  assign w_count32   = 32'(r_count);
  assign w_hdr       = w_count32[15:0];
  assign w_last_byte = (r_byte == c_last_byte);
  assign ram_rd_addr = r_addr;

  // Next-state and outputs. All outputs are functions of registered state
  // only, so m_tvalid never depends on m_tready.
  always_comb begin
    w_next    = r_state;
    busy      = 1'b0;
    done      = 1'b0;
    ram_rd_en = 1'b0;
    m_tvalid  = 1'b0;
    m_tdata   = 8'h00;
    m_tlast   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) w_next = S_HDR0;
      end
      S_HDR0: begin
        busy     = 1'b1;
        m_tvalid = 1'b1;
        m_tdata  = w_hdr[15:8];
        if (m_tready) w_next = S_HDR1;
      end
      S_HDR1: begin
        busy     = 1'b1;
        m_tvalid = 1'b1;
        m_tdata  = w_hdr[7:0];
        m_tlast  = (r_count == '0);
        if (m_tready) w_next = (r_count != '0) ? S_RD : S_DONE;
      end
      S_RD: begin
        busy      = 1'b1;
        ram_rd_en = 1'b1;
        w_next    = S_LAT;
      end
      S_LAT: begin
        busy   = 1'b1;
        w_next = S_SEND;
      end
      S_SEND: begin
        busy     = 1'b1;
        m_tvalid = 1'b1;
        m_tdata  = r_shift[c_shift_w-1 -: 8];
        // r_remain is already decremented for this sample, so zero means last.
        m_tlast  = w_last_byte && (r_remain == '0);
        if (m_tready && w_last_byte) w_next = (r_remain != '0) ? S_RD : S_DONE;
      end
      S_DONE: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_count  <= '0;
      r_remain <= '0;
      r_addr   <= '0;
      r_shift  <= '0;
      r_byte   <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_count  <= w_clamped;
            r_remain <= w_clamped;
            r_addr   <= start_addr;
          end
        end
        S_RD: begin
          // Natural overflow of r_addr gives the modulo-depth wrap.
          r_addr   <= r_addr + 1'b1;
          r_remain <= r_remain - 1'b1;
        end
        S_LAT: begin
          r_shift <= w_sample_ext;
          r_byte  <= '0;
        end
        S_SEND: begin
          if (m_tready) begin
            r_shift <= r_shift << 8;
            r_byte  <= r_byte + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_capture_dump_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_capture_dump_reader
// Purpose  : Self-checking bench for capture_dump_reader. A behavioural RAM
//            and a frame model (header + byte-split samples, expected read
//            addresses) built from the frame rules are compared with what
//            the stream monitor collects.
// Revision : 1.0 - initial release
// ============================================================================
module tb_capture_dump_reader;

  localparam int AW    = 12;
  localparam int DW    = 34;
  localparam int SB    = 5;
  localparam int DEPTH = 4096;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] start_addr = '0;
  logic [AW:0]   sample_count = '0;
  logic          busy, done, ram_rd_en;
  logic [AW-1:0] ram_rd_addr;
  logic [DW-1:0] ram_rd_data = '0;
  logic [7:0]    m_tdata;
  logic          m_tvalid, m_tlast;
  logic          m_tready = 1'b1;

  capture_dump_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SAMPLE_BYTES(SB)) dut (
    .clk(clk), .rst(rst), .start(start), .start_addr(start_addr),
    .sample_count(sample_count), .busy(busy), .done(done),
    .ram_rd_en(ram_rd_en), .ram_rd_addr(ram_rd_addr), .ram_rd_data(ram_rd_data),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast)
  );

  always #5 clk = ~clk;

  int n_pass = 0, n_fail = 0, n_checks = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Capture RAM: data only valid the cycle after a read strobe, junk otherwise.
  logic [DW-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (ram_rd_en) ram_rd_data <= mem[ram_rd_addr];
    else           ram_rd_data <= {2'($urandom), $urandom};
  end

  // Monitor
  int         cyc = 0;
  logic [7:0] got_b[$];
  bit         got_l[$];
  int         rd_a[$];
  int         done_cnt = 0, fv_cyc = -1, done_cyc = -1;
  logic       prev_stall = 1'b0, prev_last = 1'b0;
  logic [7:0] prev_data = '0;
  int         ready_mode = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst) begin
      if (prev_stall) begin
        check("hold_valid", m_tvalid, 1);
        check("hold_data", m_tdata, prev_data);
        check("hold_last", m_tlast, prev_last);
      end
      if (m_tvalid && m_tready) begin
        got_b.push_back(m_tdata);
        got_l.push_back(m_tlast);
      end
      if (ram_rd_en) rd_a.push_back(int'(ram_rd_addr));
      if (m_tvalid && fv_cyc < 0) fv_cyc = cyc;
      if (done) begin
        done_cnt = done_cnt + 1;
        done_cyc = cyc;
        check("busy_low_at_done", busy, 0);
      end
    end
    prev_stall <= !rst && m_tvalid && !m_tready;
    prev_data  <= m_tdata;
    prev_last  <= m_tlast;
  end

  // Reference model: expected frame bytes and RAM read order.
  logic [7:0] exp_b[$];
  int         exp_a[$];

  task automatic build_model(input int addr, input int cnt);
    int eff, a;
    logic [39:0] s;
    eff = (cnt > DEPTH) ? DEPTH : cnt;
    exp_b.delete();
    exp_a.delete();
    exp_b.push_back(8'(eff >> 8));
    exp_b.push_back(8'(eff));
    for (int i = 0; i < eff; i++) begin
      a = (addr + i) % DEPTH;
      s = 40'(mem[a]);
      exp_a.push_back(a);
      for (int b = SB - 1; b >= 0; b--) exp_b.push_back(s[b*8 +: 8]);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_rd_en"}, ram_rd_en, 0);
    check({tag, "_rd_addr"}, ram_rd_addr, 0);
    check({tag, "_tvalid"}, m_tvalid, 0);
    check({tag, "_tdata"}, m_tdata, 0);
    check({tag, "_tlast"}, m_tlast, 0);
  endtask

  task automatic run_dump(input string name, input int addr, input int cnt,
                          input int rmode, input bit inject, input bit timed);
    int eff, budget, n;
    bit injected;
    eff      = (cnt > DEPTH) ? DEPTH : cnt;
    budget   = 20 * eff + 100;
    injected = 0;
    build_model(addr, cnt);
    got_b.delete(); got_l.delete(); rd_a.delete();
    done_cnt = 0; fv_cyc = -1; done_cyc = -1;
    ready_mode = rmode;
    @(posedge clk); #1;
    check({name, "_idle_busy"}, busy, 0);
    start = 1'b1;
    start_addr = AW'(addr);
    sample_count = (AW+1)'(cnt);
    @(posedge clk); #1;
    start = 1'b0;
    start_addr = AW'($urandom);
    sample_count = (AW+1)'($urandom);
    check({name, "_first_valid"}, m_tvalid, 1);
    check({name, "_first_busy"}, busy, 1);
    check({name, "_first_byte"}, m_tdata, exp_b[0]);
    for (int k = 0; k < budget && done_cnt == 0; k++) begin
      @(posedge clk); #1;
      if (inject && !injected && got_b.size() >= 4) begin
        start = 1'b1;
        start_addr = AW'($urandom);
        sample_count = (AW+1)'($urandom_range(1, 40));
        injected = 1;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    check({name, "_done_seen"}, (done_cnt > 0), 1);
    repeat (4) @(posedge clk);
    #1;
    check({name, "_busy_after"}, busy, 0);
    check({name, "_done_once"}, done_cnt, 1);
    check({name, "_len"}, got_b.size(), exp_b.size());
    n = (got_b.size() < exp_b.size()) ? got_b.size() : exp_b.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_byte%0d", name, i), got_b[i], exp_b[i]);
      check($sformatf("%s_last%0d", name, i), got_l[i], (i == exp_b.size() - 1));
    end
    check({name, "_reads"}, rd_a.size(), exp_a.size());
    n = (rd_a.size() < exp_a.size()) ? rd_a.size() : exp_a.size();
    for (int i = 0; i < n; i++) check($sformatf("%s_addr%0d", name, i), rd_a[i], exp_a[i]);
    if (timed) check({name, "_done_gap"}, done_cyc - fv_cyc, 2 + 7 * eff);
    ready_mode = 0;
  endtask

  initial begin
    int a;
    fork
      forever begin
        @(posedge clk); #1;
        m_tready = (ready_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
      end
    join_none

    for (int i = 0; i < DEPTH; i++) mem[i] = {2'($urandom), $urandom};

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;

    // Basic dump with known contents
    mem[16] = 34'h2_1234_ABCD;
    mem[17] = 34'h0_0000_0001;
    run_dump("basic", 16, 2, 0, 0, 1);
    if (got_b.size() == 12) begin
      check("basic_hdr_lo", got_b[1], 8'h02);
      check("basic_s0_msb", got_b[2], 8'h02);
      check("basic_s0_lsb", got_b[6], 8'hCD);
      check("basic_s1_lsb", got_b[11], 8'h01);
    end

    run_dump("wrap", 4094, 4, 0, 0, 1);
    run_dump("zero", int'($urandom_range(0, DEPTH - 1)), 0, 0, 0, 1);
    run_dump("rand1", int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(1, 20)), 0, 0, 1);
    run_dump("rand2", DEPTH - int'($urandom_range(1, 6)), int'($urandom_range(6, 20)), 0, 0, 1);

    a = int'($urandom_range(0, DEPTH - 1));
    run_dump("bp_ref", a, 8, 0, 0, 1);
    run_dump("bp", a, 8, 1, 0, 0);

    run_dump("inject", int'($urandom_range(0, DEPTH - 1)), 3, 0, 1, 1);

    // Reset in the middle of a sample
    @(posedge clk); #1;
    got_b.delete();
    start = 1'b1;
    start_addr = AW'($urandom);
    sample_count = 13'd3;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < 50 && got_b.size() < 4; k++) begin
      @(posedge clk); #1;
    end
    check("rst_reached_send", (got_b.size() >= 4), 1);
    rst = 1'b1;
    @(posedge clk); #1;
    check_reset_outputs("midrst");
    rst = 1'b0;
    run_dump("after_rst", int'($urandom_range(0, DEPTH - 1)), 3, 0, 0, 1);

    run_dump("big", int'($urandom_range(0, DEPTH - 1)), 5000, 0, 0, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
